// File: rtl/second_timestamper_if.sv
// second_timestamper_if
//   Timestamp output stream of second_timestamper. The producer presents the
//   FIFO head entry, and the consumer accepts it with ts_ready.
//   Signals:
//     ts_valid  head entry present (FIFO non-empty)
//     ts_ready  consumer accepts the head entry this cycle
//     ts_sec    head entry seconds count
//     ts_sub    head entry sub-second count
//     ts_stale  head entry was captured while the clk1 reference was lost
//   Modports: master = timestamper side, slave = consumer side.
interface second_timestamper_if #(
  parameter int SEC_W = 32,
  parameter int SUB_W = 8
);
  logic             ts_valid;
  logic             ts_ready;
  logic [SEC_W-1:0] ts_sec;
  logic [SUB_W-1:0] ts_sub;
  logic             ts_stale;

  modport master (output ts_valid, ts_sec, ts_sub, ts_stale, input ts_ready);
  modport slave  (input ts_valid, ts_sec, ts_sub, ts_stale, output ts_ready);
endinterface

// File: rtl/second_timestamper.sv
// second_timestamper
//   Tracks seconds and sub-second cycles against the divided clk1 reference,
//   which is sampled as data in the clk50 domain. Trigger strobes are stamped
//   with {sec, sub, stale} into a small first-word-fall-through FIFO. The block
//   also records the sub-second phase of the divider's marker pulse, and it
//   flags loss of the clk1 reference.
//   Ports:
//     clk50        system clock
//     rst          asynchronous, active-high reset
//     clk1         divided clock (level, sampled every clk50 cycle)
//     pulse        single-cycle marker from the divider
//     trig         single-cycle event strobe to timestamp
//     clr_ovf      clears the sticky overflow and lost flags
//     ts           timestamp stream (master side), head entry combinational
//     fifo_count   FIFO occupancy
//     overflow     sticky: a trigger was dropped because the FIFO was full
//     lost         sticky: TIMEOUT cycles elapsed without a clk1 rise
//     synced       state is SYNCED
//     pulse_phase  sub value sampled on the last accepted pulse
module second_timestamper #(
  parameter  int SEC_W   = 32,
  parameter  int SUB_W   = 8,
  parameter  int TIMEOUT = 104,
  parameter  int DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             clk1,
  input  logic             pulse,
  input  logic             trig,
  input  logic             clr_ovf,
  second_timestamper_if.master ts,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             lost,
  output logic             synced,
  output logic [SUB_W-1:0] pulse_phase
);

  typedef enum logic [1:0] {UNSYNC, SYNCED, LOST} state_t;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [SUB_W-1:0] sub;
    logic             stale;
  } entry_t;

  localparam logic [SUB_W-1:0] SUB_TO  = SUB_W'(TIMEOUT - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_t           state;
  logic             clk1_q;
  logic [SEC_W-1:0] sec;
  logic [SUB_W-1:0] sub;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             rise;
  logic             timeout_hit;
  logic [SUB_W-1:0] sub_inc;
  logic             push_req;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             drop;
  entry_t           wr_entry;
  entry_t           head;

  // ---------------------------------------------------------------------------
  // Reference tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    rise        = clk1 & ~clk1_q;
    // Only SYNCED can time out; LOST just keeps counting.
    timeout_hit = (state == SYNCED) && !rise && (sub == SUB_TO);
    sub_inc     = (sub == SUB_MAX) ? sub : sub + SUB_W'(1);
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state  <= UNSYNC;
      clk1_q <= 1'b0;
      sec    <= '0;
      sub    <= '0;
    end else begin
      clk1_q <= clk1;
      case (state)
        UNSYNC: begin
          if (rise) begin
            state <= SYNCED;
            sec   <= '0;
            sub   <= '0;
          end
        end
        SYNCED: begin
          if (rise) begin
            sec <= sec + SEC_W'(1);
            sub <= '0;
          end else begin
            if (timeout_hit) state <= LOST;
            sub <= sub_inc;
          end
        end
        LOST: begin
          if (rise) begin
            state <= SYNCED;
            sec   <= sec + SEC_W'(1);
            sub   <= '0;
          end else begin
            sub <= sub_inc;
          end
        end
        default: state <= UNSYNC;
      endcase
    end
  end

  assign synced = (state == SYNCED);

  // Sticky flags: a set event in the same cycle beats the clear.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      lost        <= 1'b0;
      overflow    <= 1'b0;
      pulse_phase <= '0;
    end else begin
      if (timeout_hit)  lost <= 1'b1;
      else if (clr_ovf) lost <= 1'b0;

      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (pulse && state != UNSYNC) pulse_phase <= sub;
    end
  end

  // ---------------------------------------------------------------------------
  // Timestamp FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  always_comb begin
    // The entry uses this cycle's register values, i.e. before any rise update.
    push_req       = trig && (state != UNSYNC);
    full           = (count == CNT_FULL);
    pop            = (count != '0) && ts.ts_ready;
    // A pop frees a slot in the same cycle, so full+pop still accepts the push.
    do_push        = push_req && (!full || pop);
    drop           = push_req && full && !pop;
    wr_entry.sec   = sec;
    wr_entry.sub   = sub;
    wr_entry.stale = (state == LOST);
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head        = mem[rd_ptr];
    ts.ts_valid = (count != '0);
    ts.ts_sec   = head.sec;
    ts.ts_sub   = head.sub;
    ts.ts_stale = head.stale;
  end

  assign fifo_count = count;

endmodule

// File: doc/second_timestamper.md
Name: second_timestamper

Overview:
- Consumes the 1 Hz-class divided clock (clk1) and its mid-period marker (pulse) produced by the clock-divider stage in the clk50 domain.
- Keeps a seconds counter and a sub-second cycle counter aligned to clk1 rising edges.
- Timestamps single-cycle trigger strobes into a small first-word-fall-through FIFO with a valid/ready output, for event logging downstream.
- Also measures the phase of the marker pulse and detects loss of the clk1 reference.

Parameters:
SEC_W, 32, seconds counter width (wraps)
SUB_W, 8, sub-second counter width (saturates at all-ones)
TIMEOUT, 104, clk50 cycles after the last clk1 rise before declaring reference lost
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk50  in  1  system clock
rst  in  1  asynchronous, active-high reset
clk1  in  1  divided clock from the divider, treated as data in clk50 domain
pulse  in  1  single-cycle marker from the divider
trig  in  1  single-cycle event strobe to timestamp
clr_ovf  in  1  clears sticky overflow and lost flags
ts_ready  in  1  consumer accepts head entry
ts_valid  out  1  FIFO non-empty
ts_sec  out  SEC_W  head entry seconds
ts_sub  out  SUB_W  head entry sub-second count
ts_stale  out  1  head entry captured while in LOST
fifo_count  out  $clog2(DEPTH+1)  occupancy
overflow  out  1  sticky: trigger dropped because FIFO full
lost  out  1  sticky: TIMEOUT expired without clk1 rise
synced  out  1  state == SYNCED
pulse_phase  out  SUB_W  sub value sampled on last pulse

Behaviour:
- Async reset: all registers and outputs 0; clk1_q=0; state=UNSYNC.
- rise = clk1 & ~clk1_q, with clk1_q registered every cycle.
- States:
  - UNSYNC: on rise -> SYNCED, sec=0, sub=0.
  - SYNCED: on rise -> sec=sec+1 (wrap), sub=0. Else if sub==TIMEOUT-1 -> LOST, lost=1, sub increments.
  - LOST: on rise -> SYNCED, sec=sec+1, sub=0.
- sub counter: in SYNCED/LOST, when there is no rise, sub increments and saturates at 2^SUB_W-1. In UNSYNC, sub stays 0.
- Capture:
  - trig pushes {sec, sub, stale=(state==LOST)} using the register values present in the trig cycle, i.e. before that cycle's update. A trig coincident with rise therefore gets the old sec/sub.
  - trig in UNSYNC is discarded with no flag.
- FIFO:
  - Output fields show the head entry combinationally.
  - pop = ts_valid & ts_ready.
  - Push while full with no pop: entry dropped, overflow=1.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only. Pop requires ts_valid.
  - Pointers wrap modulo DEPTH.
- pulse: pulse_phase <= sub in the cycle pulse is high. Ignored in UNSYNC.
- clr_ovf: clears overflow and lost next cycle. A same-cycle set event wins over the clear.
- Latency: trig to ts_valid is 1 cycle when empty. rise to sub=0 visible is 1 cycle.
- Reset mid-operation: FIFO contents are discarded, and state returns to UNSYNC immediately.

Test Plan:
1. Reset, 20 cycles without clk1 rise, trig pulses -> ts_valid=0, synced=0, fifo_count=0.
2. clk1 period 52 cycles, ts_ready=1; trig when sub=10 after first rise -> ts_sec=0, ts_sub=10, ts_stale=0 one cycle later. After second rise, trig at sub=5 -> ts_sec=1, ts_sub=5.
3. trig in the same cycle as the 2nd rise (sub=51) -> entry sec=0, sub=51. Next cycle internal sec=1, sub=0.
4. ts_ready=0, 5 trigs at sub 1..5 with DEPTH=4 -> fifo_count=4, overflow=1. Then ready=1 pops sub 1,2,3,4 in order. clr_ovf -> overflow=0.
5. After rise, hold clk1 low for 110 cycles -> lost=1, synced=0 at sub=104. trig -> ts_stale=1. Next rise -> synced=1, sec incremented by 1.
6. pulse injected when sub=16 -> pulse_phase=16. Assert rst mid-FIFO (count=3) -> ts_valid, fifo_count, and pulse_phase are 0 before the next clk50 edge.
